mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage_if.sv | 29 ++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/response bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  // Pipeline side: issues the access and waits for the completion pulse.
  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_ack,
    input  dm_rdata
  );

  // Memory side: accepts the access and returns the completion pulse.
  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_ack,
    output dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: data-memory access, stall, redirect and MEM/WB register
module mem_access_stage (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          npc_in,
  input  logic [31:0]          alu_c_in,
  input  logic [31:0]          rt_data_in,
  input  logic                 zero_in,
  input  logic [4:0]           reg_rd_in,
  input  logic [1:0]           branch_in,
  input  logic [1:0]           jump_in,
  input  logic                 memr_in,
  input  logic                 memw_in,
  input  logic                 regw_in,
  input  logic                 mem2r_in,
  mem_access_stage_if.master   dm,
  output logic                 mem_stall,
  output logic                 redirect,
  output logic [31:0]          redirect_pc,
  output logic                 dm_err,
  output logic                 wb_regw,
  output logic                 wb_mem2r,
  output logic [4:0]           wb_rd,
  output logic [31:0]          wb_alu_c,
  output logic [31:0]          wb_mem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  tmo_cnt;
  logic        mem_op;
  logic        branch_taken;
  logic        jump_taken;
  logic        timeout;
  logic        complete;

  // Decoded control: reserved branch/jump codes fall through as "no transfer".
  assign mem_op       = memr_in | memw_in;
  assign branch_taken = ((branch_in == 2'b01) &&  zero_in) ||
                        ((branch_in == 2'b10) && !zero_in);
  assign jump_taken   = (jump_in == 2'b01) || (jump_in == 2'b10);
  assign timeout      = (tmo_cnt == 8'd255) && !dm.dm_ack;
  assign complete     = dm.dm_ack || timeout;

  // State register; reset abandons any outstanding access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus the combinational stall and redirect outputs.
  always_comb begin
    state_d     = state_q;
    mem_stall   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = (jump_in == 2'b10) ? alu_c_in : npc_in;
    case (state_q)
      IDLE: begin
        redirect = branch_taken || jump_taken;
        if (mem_op) begin
          mem_stall = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        mem_stall = 1'b1;
        if (complete) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory request registers, timeout counter, sticky error and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt     <= 8'd0;
      dm.dm_req   <= 1'b0;
      dm.dm_we    <= 1'b0;
      dm.dm_addr  <= 32'd0;
      dm.dm_wdata <= 32'd0;
      dm_err      <= 1'b0;
      wb_regw     <= 1'b0;
      wb_mem2r    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_alu_c    <= 32'd0;
      wb_mem_data <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            // Launch the access; the write-back slot stays empty until completion.
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= memw_in;
            dm.dm_addr  <= {alu_c_in[31:2], 2'b00};
            dm.dm_wdata <= rt_data_in;
            tmo_cnt     <= 8'd0;
            wb_regw     <= 1'b0;
          end else begin
            wb_regw     <= regw_in;
            wb_mem2r    <= mem2r_in;
            wb_rd       <= reg_rd_in;
            wb_alu_c    <= alu_c_in;
            wb_mem_data <= 32'd0;
          end
        end
        BUSY: begin
          if (complete) begin
            // EX/MEM is frozen during BUSY, so the inputs still describe this access.
            dm.dm_req   <= 1'b0;
            dm.dm_we    <= 1'b0;
            wb_regw     <= regw_in;
            wb_mem2r    <= mem2r_in;
            wb_rd       <= reg_rd_in;
            wb_alu_c    <= alu_c_in;
            wb_mem_data <= (dm.dm_ack && !dm.dm_we) ? dm.dm_rdata : 32'd0;
            if (timeout) begin
              dm_err <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          // Bubble: the completed instruction must not be written back twice.
          wb_regw <= 1'b0;
        end
        default: begin
          wb_regw <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc_in, alu_c_in, rt_data_in;
  logic        zero_in;
  logic [4:0]  reg_rd_in;
  logic [1:0]  branch_in, jump_in;
  logic        memr_in, memw_in, regw_in, mem2r_in;
  logic        mem_stall, redirect, dm_err;
  logic [31:0] redirect_pc;
  logic        wb_regw, wb_mem2r;
  logic [4:0]  wb_rd;
  logic [31:0] wb_alu_c, wb_mem_data;

  mem_access_stage_if dm_bus ();

  mem_access_stage dut (
    .clk         (clk),
    .rst         (rst),
    .npc_in      (npc_in),
    .alu_c_in    (alu_c_in),
    .rt_data_in  (rt_data_in),
    .zero_in     (zero_in),
    .reg_rd_in   (reg_rd_in),
    .branch_in   (branch_in),
    .jump_in     (jump_in),
    .memr_in     (memr_in),
    .memw_in     (memw_in),
    .regw_in     (regw_in),
    .mem2r_in    (mem2r_in),
    .dm          (dm_bus),
    .mem_stall   (mem_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dm_err      (dm_err),
    .wb_regw     (wb_regw),
    .wb_mem2r    (wb_mem2r),
    .wb_rd       (wb_rd),
    .wb_alu_c    (wb_alu_c),
    .wb_mem_data (wb_mem_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        regw;
    logic        mem2r;
    logic [4:0]  rd;
    logic [31:0] alu_c;
    logic [31:0] mem_data;
  } wb_t;

  wb_t sb[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] npc, input logic [31:0] alu_c, input logic [31:0] rt,
                        input logic zero, input logic [4:0] rd, input logic [1:0] br,
                        input logic [1:0] jp, input logic mr, input logic mw,
                        input logic rw, input logic m2r);
    npc_in = npc; alu_c_in = alu_c; rt_data_in = rt; zero_in = zero; reg_rd_in = rd;
    branch_in = br; jump_in = jp; memr_in = mr; memw_in = mw; regw_in = rw; mem2r_in = m2r;
  endtask

  task automatic nop;
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_wb(input string tag);
    wb_t e;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_wb_regw"},     {31'd0, wb_regw},  {31'd0, e.regw});
      chk({tag, "_wb_mem2r"},    {31'd0, wb_mem2r}, {31'd0, e.mem2r});
      chk({tag, "_wb_rd"},       {27'd0, wb_rd},    {27'd0, e.rd});
      chk({tag, "_wb_alu_c"},    wb_alu_c,          e.alu_c);
      chk({tag, "_wb_mem_data"}, wb_mem_data,       e.mem_data);
    end
  endtask

  // Acts as data memory: acks when dm_req has been seen for 'delay' cycles (0 = never).
  // Returns once the stage leaves the stall (DONE cycle), sampling the bus while requesting.
  task automatic run_mem(input int delay, input logic [31:0] rdata,
                         output int stalls, output int busy,
                         output logic [31:0] addr, output logic we,
                         output logic [31:0] wdata, output logic err_before);
    int age;
    bit done;
    age = 0; done = 0;
    stalls = 0; addr = '0; we = 1'b0; wdata = '0; err_before = 1'b0;
    #1;
    for (int c = 0; c < 400 && !done; c++) begin
      if (mem_stall) stalls++;
      if (dm_bus.dm_req) begin
        age++;
        addr = dm_bus.dm_addr; we = dm_bus.dm_we; wdata = dm_bus.dm_wdata;
        err_before = dm_err;
      end
      if (stalls > 0 && !mem_stall) begin
        done = 1;
      end else begin
        dm_bus.dm_ack   = dm_bus.dm_req && (age == delay);
        dm_bus.dm_rdata = rdata;
        tick();
      end
    end
    dm_bus.dm_ack = 1'b0;
    busy = age;
    chk("mem_done_in_bound", {31'd0, done}, 32'd1);
  endtask

  task automatic check_br(input string tag, input logic [1:0] br, input logic [1:0] jp,
                          input logic zero, input logic [31:0] npc, input logic [31:0] alu_c,
                          input logic exp_redir, input logic [31:0] exp_pc);
    set_op(npc, alu_c, 32'd0, zero, 5'd0, br, jp, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk({tag, "_redirect"},    {31'd0, redirect}, {31'd0, exp_redir});
    chk({tag, "_redirect_pc"}, redirect_pc,       exp_pc);
  endtask

  int          stalls, busy;
  logic [31:0] addr, wdata;
  logic        we, err_before;

  initial begin
    nop();
    dm_bus.dm_ack = 1'b0;
    dm_bus.dm_rdata = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    // Asynchronous reset, before any clock edge
    chk("rst_dm_req",      {31'd0, dm_bus.dm_req}, 32'd0);
    chk("rst_dm_we",       {31'd0, dm_bus.dm_we},  32'd0);
    chk("rst_dm_addr",     dm_bus.dm_addr,         32'd0);
    chk("rst_dm_wdata",    dm_bus.dm_wdata,        32'd0);
    chk("rst_dm_err",      {31'd0, dm_err},        32'd0);
    chk("rst_wb_regw",     {31'd0, wb_regw},       32'd0);
    chk("rst_wb_rd",       {27'd0, wb_rd},         32'd0);
    chk("rst_wb_alu_c",    wb_alu_c,               32'd0);
    chk("rst_wb_mem_data", wb_mem_data,            32'd0);
    chk("rst_mem_stall",   {31'd0, mem_stall},     32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // ALU op, with a stray dm_ack that must be ignored
    set_op(32'd0, 32'h10, 32'd0, 1'b0, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{regw: 1'b1, mem2r: 1'b0, rd: 5'd5, alu_c: 32'h10, mem_data: 32'd0});
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hFFFF_FFFF;
    #1;
    chk("alu_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("alu_redirect",  {31'd0, redirect},  32'd0);
    tick();
    dm_bus.dm_ack = 1'b0;
    check_wb("alu");
    chk("alu_stall_after", {31'd0, mem_stall},     32'd0);
    chk("alu_no_req",      {31'd0, dm_bus.dm_req}, 32'd0);
    nop();
    tick();
    chk("alu_nop_wb_regw", {31'd0, wb_regw}, 32'd0);

    // Load, ack 3 cycles after dm_req
    set_op(32'd0, 32'h103, 32'd0, 1'b0, 5'd7, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    sb.push_back('{regw: 1'b1, mem2r: 1'b1, rd: 5'd7, alu_c: 32'h103, mem_data: 32'hDEAD_BEEF});
    run_mem(3, 32'hDEAD_BEEF, stalls, busy, addr, we, wdata, err_before);
    chk("ld_stall_cycles", stalls, 32'd4);
    chk("ld_busy_cycles",  busy,   32'd3);
    chk("ld_dm_addr",      addr,   32'h100);
    chk("ld_dm_we",        {31'd0, we}, 32'd0);
    check_wb("ld");
    chk("ld_done_req", {31'd0, dm_bus.dm_req}, 32'd0);
    jump_in = 2'b01;
    #1;
    chk("ld_done_redirect", {31'd0, redirect}, 32'd0);
    nop();
    tick();
    chk("ld_bubble_wb_regw", {31'd0, wb_regw}, 32'd0);
    tick();

    // Store, ack 2 cycles after dm_req
    set_op(32'd0, 32'h200, 32'h55, 1'b0, 5'd9, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back('{regw: 1'b0, mem2r: 1'b0, rd: 5'd9, alu_c: 32'h200, mem_data: 32'd0});
    run_mem(2, 32'hCAFE_F00D, stalls, busy, addr, we, wdata, err_before);
    chk("st_stall_cycles", stalls, 32'd3);
    chk("st_dm_we",        {31'd0, we}, 32'd1);
    chk("st_dm_wdata",     wdata,  32'h55);
    chk("st_dm_addr",      addr,   32'h200);
    check_wb("st");
    nop();
    tick();
    tick();

    // Redirect decode in IDLE
    check_br("beq_taken",  2'b01, 2'b00, 1'b1, 32'h40,  32'h99, 1'b1, 32'h40);
    check_br("beq_not",    2'b01, 2'b00, 1'b0, 32'h40,  32'h99, 1'b0, 32'h40);
    check_br("bne_not",    2'b10, 2'b00, 1'b1, 32'h40,  32'h99, 1'b0, 32'h40);
    check_br("bne_taken",  2'b10, 2'b00, 1'b0, 32'h60,  32'h99, 1'b1, 32'h60);
    check_br("jr",         2'b00, 2'b10, 1'b0, 32'h44,  32'h80, 1'b1, 32'h80);
    check_br("j",          2'b00, 2'b01, 1'b0, 32'h300, 32'h99, 1'b1, 32'h300);
    check_br("br_rsvd",    2'b11, 2'b00, 1'b1, 32'h50,  32'h99, 1'b0, 32'h50);
    check_br("jp_rsvd",    2'b00, 2'b11, 1'b0, 32'h54,  32'h99, 1'b0, 32'h54);
    check_br("jr_over_br", 2'b01, 2'b10, 1'b1, 32'h70,  32'h88, 1'b1, 32'h88);
    nop();
    tick();

    // Load with no ack: timeout after 256 BUSY cycles
    set_op(32'd0, 32'h3FC, 32'd0, 1'b0, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    sb.push_back('{regw: 1'b1, mem2r: 1'b1, rd: 5'd3, alu_c: 32'h3FC, mem_data: 32'd0});
    run_mem(0, 32'h1234_5678, stalls, busy, addr, we, wdata, err_before);
    chk("tmo_busy_cycles",  busy,   32'd256);
    chk("tmo_stall_cycles", stalls, 32'd257);
    chk("tmo_err_before",   {31'd0, err_before}, 32'd0);
    chk("tmo_dm_err",       {31'd0, dm_err},     32'd1);
    check_wb("tmo");
    nop();
    tick();

    // Back in IDLE: a plain ALU op completes in one cycle, error stays sticky
    set_op(32'd0, 32'h20, 32'd0, 1'b0, 5'd4, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    sb.push_back('{regw: 1'b1, mem2r: 1'b0, rd: 5'd4, alu_c: 32'h20, mem_data: 32'd0});
    #1;
    chk("post_tmo_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    check_wb("post_tmo");
    chk("err_sticky", {31'd0, dm_err}, 32'd1);
    nop();
    tick();

    // Reset in the middle of a BUSY load
    set_op(32'd0, 32'h500, 32'd0, 1'b0, 5'd8, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("rbusy_req_up", {31'd0, dm_bus.dm_req}, 32'd1);
    jump_in = 2'b01;
    #1;
    chk("busy_redirect", {31'd0, redirect}, 32'd0);
    jump_in = 2'b00;
    #1;
    rst = 1'b1;
    #1;
    chk("rbusy_req_drop", {31'd0, dm_bus.dm_req}, 32'd0);
    chk("rbusy_wb_regw",  {31'd0, wb_regw},       32'd0);
    chk("rbusy_err_clr",  {31'd0, dm_err},        32'd0);
    chk("rbusy_addr_clr", dm_bus.dm_addr,         32'd0);
    nop();
    tick();
    rst = 1'b0;
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'hABCD_0123;
    tick();
    dm_bus.dm_ack = 1'b0;
    chk("late_ack_wb_regw", {31'd0, wb_regw},       32'd0);
    chk("late_ack_wb_data", wb_mem_data,            32'd0);
    chk("late_ack_req",     {31'd0, dm_bus.dm_req}, 32'd0);
    chk("late_ack_stall",   {31'd0, mem_stall},     32'd0);
    chk("sb_drained",       sb.size(),              32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
